// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding halfword fetcher feeding a prefetch FIFO,
// issuing one instruction per cycle to Decode and redirecting on Execute branches.
module instruction_fetch #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 4,
  parameter int                PIPE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  input  logic              global_disable,
  input  logic              branch_taken,
  input  logic [31:0]       delta_instruction,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;

  logic [15:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [15:0]       instr_reg;
  logic              instr_valid_reg;
  logic [ADDR_W-1:0] instr_pc_reg;

  logic              hist_valid_reg [PIPE_DEPTH];
  logic [ADDR_W-1:0] hist_pc_reg    [PIPE_DEPTH];
  logic              hist_valid_in  [PIPE_DEPTH];
  logic [ADDR_W-1:0] hist_pc_in     [PIPE_DEPTH];

  logic               redirect;
  logic               push;
  logic               pop;
  logic signed [32:0] delta_x2;
  logic [ADDR_W-1:0]  target;

  // A branch only counts when the instruction Execute is looking at was real.
  assign redirect = branch_taken & hist_valid_reg[PIPE_DEPTH-1];
  assign delta_x2 = {delta_instruction, 1'b0};
  assign target   = hist_pc_reg[PIPE_DEPTH-1] + ADDR_W'(delta_x2);
  assign push     = (state_reg == REQ) & mem_ack & ~redirect;
  assign pop      = (count_reg != '0) & ~global_disable & ~redirect;

  assign count_next    = redirect ? '0 : count_reg + CNT_W'(push) - CNT_W'(pop);
  assign fetch_pc_next = redirect ? target : (push ? fetch_pc_reg + ADDR_W'(2) : fetch_pc_reg);
  // A stale request keeps its original address until the memory completes it.
  assign mem_addr_next = (state_next == DROP) ? mem_addr_reg : fetch_pc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (redirect || count_reg != FULL) state_next = REQ;
      REQ: begin
        if (redirect)     state_next = mem_ack ? REQ : DROP;
        else if (mem_ack) state_next = (count_next != FULL) ? REQ : IDLE;
      end
      DROP:    if (mem_ack) state_next = REQ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req = (state_reg != IDLE);
  end

  assign mem_addr    = mem_addr_reg;
  assign instruction = instr_reg;
  assign instr_valid = instr_valid_reg;
  assign instr_pc    = instr_pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg    <= RESET_PC;
      mem_addr_reg    <= RESET_PC;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      instr_reg       <= '0;
      instr_valid_reg <= 1'b0;
      instr_pc_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      mem_addr_reg <= mem_addr_next;
      count_reg    <= count_next;
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        instr_reg       <= fifo_data[rd_ptr_reg];
        instr_pc_reg    <= fifo_pc[rd_ptr_reg];
        instr_valid_reg <= 1'b1;
      end else begin
        instr_reg       <= '0;
        instr_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_reg] <= mem_rdata;
      fifo_pc[wr_ptr_reg]   <= fetch_pc_reg;
    end
  end

  for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign hist_valid_in[gi] = instr_valid_reg;
      assign hist_pc_in[gi]    = instr_pc_reg;
    end else begin : g_tail
      assign hist_valid_in[gi] = hist_valid_reg[gi-1];
      assign hist_pc_in[gi]    = hist_pc_reg[gi-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        hist_valid_reg[i] <= 1'b0;
        hist_pc_reg[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        hist_valid_reg[i] <= hist_valid_in[i] & ~redirect;
        hist_pc_reg[i]    <= hist_pc_in[i];
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall, two redirects, mid-stream reset.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        global_disable = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] delta_instruction = '0;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [31:0] instr_pc;

  int n_assert = 0;
  int n_fail = 0;
  int wait_states = 0;
  int wait_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_W(32), .RESET_PC(32'h0), .FIFO_DEPTH(4), .PIPE_DEPTH(2)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .global_disable(global_disable), .branch_taken(branch_taken),
    .delta_instruction(delta_instruction),
    .instruction(instruction), .instr_valid(instr_valid), .instr_pc(instr_pc)
  );

  function automatic logic [15:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 16'h2005;
      32'h2:   return 16'h1FC2;
      32'h4:   return 16'h628A;
      default: return 16'hA000 | {4'h0, a[11:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder with programmable wait states, then advance one clock.
  task automatic tick();
    if (!reset || !mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (wait_cnt >= wait_states) begin
      mem_ack   = 1'b1;
      mem_rdata = memword(mem_addr);
      wait_cnt  = 0;
    end else begin
      mem_ack = 1'b0;
      wait_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr", instruction, 16'h0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", instr_pc, 32'h0);
    $display("reset held: mem_req=%0d instr_valid=%0d", mem_req, instr_valid);

    reset = 1'b1;
    tick();
    chk("rel_mem_req", mem_req, 1);
    chk("rel_mem_addr", mem_addr, 32'h0);
    tick();
    chk("zw_addr2", mem_addr, 32'h2);
    chk("zw_novalid", instr_valid, 0);
    tick();
    chk("zw_instr0", instruction, 16'h2005);
    chk("zw_pc0", instr_pc, 32'h0);
    chk("zw_valid0", instr_valid, 1);
    chk("zw_addr4", mem_addr, 32'h4);
    tick();
    chk("zw_instr1", instruction, 16'h1FC2);
    chk("zw_pc1", instr_pc, 32'h2);
    tick();
    chk("zw_instr2", instruction, 16'h628A);
    chk("zw_pc2", instr_pc, 32'h4);
    chk("zw_addr8", mem_addr, 32'h8);
    $display("stream: instr=%h pc=%h", instruction, instr_pc);

    global_disable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gd_nop_valid", instr_valid, 0);
      chk("gd_nop_instr", instruction, 16'h0);
      chk("gd_pc_hold", instr_pc, 32'h4);
    end
    chk("gd_full_req", mem_req, 0);
    chk("gd_full_addr", mem_addr, 32'hE);
    $display("stall: mem_req=%0d mem_addr=%h", mem_req, mem_addr);
    global_disable = 1'b0;
    tick();
    chk("gd_rel_instr", instruction, 16'hA006);
    chk("gd_rel_pc", instr_pc, 32'h6);
    chk("gd_rel_req", mem_req, 0);
    tick();
    chk("gd_rel_pc8", instr_pc, 32'h8);
    chk("gd_rel_req2", mem_req, 1);
    chk("gd_rel_addr", mem_addr, 32'hE);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("gd_order_pc", instr_pc, 32'hA + 32'(2 * k));
      chk("gd_order_valid", instr_valid, 1);
    end
    $display("drain: instr=%h pc=%h", instruction, instr_pc);

    branch_taken = 1'b1;
    delta_instruction = 32'hFFFF_FFFC;
    tick();
    chk("br_addr", mem_addr, 32'h8);
    chk("br_req", mem_req, 1);
    chk("br_nop_valid", instr_valid, 0);
    chk("br_nop_instr", instruction, 16'h0);
    chk("br_pc_hold", instr_pc, 32'h14);
    branch_taken = 1'b0;
    delta_instruction = '0;
    tick();
    chk("br_flush_valid", instr_valid, 0);
    chk("br_addr_a", mem_addr, 32'hA);
    tick();
    chk("br_first_pc", instr_pc, 32'h8);
    chk("br_first_instr", instruction, 16'hA008);
    $display("redirect: first instr=%h pc=%h", instruction, instr_pc);

    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("st_pc", instr_pc, 32'h8 + 32'(2 * k));
    end
    chk("ws_addr20", mem_addr, 32'h20);
    wait_states = 3;
    tick();
    chk("ws_pc1e", instr_pc, 32'h1E);
    chk("ws_addr_hold", mem_addr, 32'h20);
    tick();
    chk("ws_empty", instr_valid, 0);
    chk("ws_req", mem_req, 1);
    branch_taken = 1'b1;
    delta_instruction = 32'd18;
    tick();
    chk("drop_req", mem_req, 1);
    chk("drop_addr", mem_addr, 32'h20);
    chk("drop_valid", instr_valid, 0);
    branch_taken = 1'b0;
    delta_instruction = '0;
    tick();
    chk("drop_new_addr", mem_addr, 32'h40);
    chk("drop_new_req", mem_req, 1);
    chk("drop_discard", instr_valid, 0);
    wait_states = 0;
    tick();
    chk("drop_no_stale", instr_valid, 0);
    chk("drop_addr42", mem_addr, 32'h42);
    tick();
    chk("drop_target_instr", instruction, 16'hA040);
    chk("drop_target_pc", instr_pc, 32'h40);
    $display("drop: instr=%h pc=%h", instruction, instr_pc);

    chk("mid_req_before", mem_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_instr", instruction, 16'h0);
    chk("mid_rst_valid", instr_valid, 0);
    chk("mid_rst_pc", instr_pc, 32'h0);
    tick();
    chk("mid_rst_hold", mem_req, 0);
    reset = 1'b1;
    tick();
    chk("restart_req", mem_req, 1);
    chk("restart_addr", mem_addr, 32'h0);
    tick();
    chk("restart_addr2", mem_addr, 32'h2);
    tick();
    chk("restart_instr", instruction, 16'h2005);
    chk("restart_pc", instr_pc, 32'h0);
    $display("restart: instr=%h pc=%h", instruction, instr_pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
